// File: rtl/victim_buffer_if.sv
// Bus bundle for the victim buffer.
// It carries the d_cache-facing port (cache2vb_* / vb2cache_*) and the
// memory-facing port (vb2mem_* / mem2vb_*).
// The slave modport is the buffer itself; the master modport is the
// environment, which is the d_cache plus main memory.
interface victim_buffer_if;
    logic [31:0] cache2vb_address;
    logic [63:0] cache2vb_data;
    logic [1:0]  cache2vb_command;
    logic [3:0]  vb2cache_response;
    logic [3:0]  vb2cache_tag;
    logic [63:0] vb2cache_data;
    logic [31:0] vb2mem_address;
    logic [63:0] vb2mem_data;
    logic [1:0]  vb2mem_command;
    logic [3:0]  mem2vb_response;
    logic [3:0]  mem2vb_tag;
    logic [63:0] mem2vb_data;

    modport slave (
        input  cache2vb_address, cache2vb_data, cache2vb_command,
        output vb2cache_response, vb2cache_tag, vb2cache_data,
        output vb2mem_address, vb2mem_data, vb2mem_command,
        input  mem2vb_response, mem2vb_tag, mem2vb_data
    );

    modport master (
        output cache2vb_address, cache2vb_data, cache2vb_command,
        input  vb2cache_response, vb2cache_tag, vb2cache_data,
        input  vb2mem_address, vb2mem_data, vb2mem_command,
        output mem2vb_response, mem2vb_tag, mem2vb_data
    );
endinterface

// File: rtl/victim_buffer.sv
// Fully-associative victim buffer between the d_cache memory port and main memory.
//
// Dirty lines written back by the d_cache are held in the buffer.
// A later allocate load that hits one of them is served from the buffer,
// and the hit line moves back to the d_cache.
// Load misses pass straight through to memory.
// A line displaced from a full buffer goes to a one-entry spill register.
// The spill register drains to memory during idle memory-port cycles.
//
// Optional build macro VB_STATS_EN enables the hit/miss counters.
// Without it, both counters are tied to 0.
module victim_buffer #(
    parameter int         VB_ENTRIES = 4,
    parameter logic [3:0] VB_TAG     = 4'd15
) (
    input  logic                 clk,
    input  logic                 reset,
    victim_buffer_if.slave       bus,
    output logic [31:0]          vb_hit_counter,
    output logic [31:0]          vb_miss_counter
);
    localparam int IDX_W = (VB_ENTRIES > 1) ? $clog2(VB_ENTRIES) : 1;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef struct packed {
        logic        vld;
        logic [28:0] addr;
        logic [63:0] data;
    } line_t;

    typedef enum logic {IDLE, DRAIN} drain_state_t;

    line_t [VB_ENTRIES-1:0] ent;
    line_t                  spill;
    logic  [IDX_W-1:0]      rr_ptr;
    drain_state_t           state;
    logic                   ret_vld;
    logic  [63:0]           ret_data;

    logic [28:0]            req_line;
    logic                   is_load, is_store;
    logic [VB_ENTRIES-1:0]  hit_vec, free_vec;
    logic                   any_hit, any_free, spill_hit;
    logic [IDX_W-1:0]       hit_idx, free_idx;
    logic                   load_hit, load_miss, load_spill;
    logic                   st_ent, st_spill, st_free, st_evict, st_around;
    logic                   fwd, drain_go, drain_done;
    line_t                  new_line;
    logic                   unused_addr_bits;

    assign req_line         = bus.cache2vb_address[31:3];
    assign unused_addr_bits = ^bus.cache2vb_address[2:0];
    assign is_load          = (bus.cache2vb_command == BUS_LOAD);
    assign is_store         = (bus.cache2vb_command == BUS_STORE);
    assign new_line         = '{vld: 1'b1, addr: req_line, data: bus.cache2vb_data};

    // Per-entry tag compare and free flag.
    for (genvar g = 0; g < VB_ENTRIES; g++) begin : g_ent
        assign hit_vec[g]  = ent[g].vld && (ent[g].addr == req_line);
        assign free_vec[g] = !ent[g].vld;
    end

    assign any_hit   = |hit_vec;
    assign any_free  = |free_vec;
    assign spill_hit = spill.vld && (spill.addr == req_line);

    // Encode the hit entry and the lowest-index free entry.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = VB_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i])  hit_idx  = IDX_W'(i);
            if (free_vec[i]) free_idx = IDX_W'(i);
        end
    end

    // Classify the upstream request. The classes are mutually exclusive.
    // A matching store (entry or spill) updates in place, so each line
    // lives in at most one place.
    assign load_hit   = is_load && (any_hit || spill_hit);
    assign load_miss  = is_load && !load_hit;
    assign load_spill = is_load && !any_hit && spill_hit;
    assign st_ent     = is_store && any_hit;
    assign st_spill   = is_store && !any_hit && spill_hit;
    assign st_free    = is_store && !any_hit && !spill_hit && any_free;
    assign st_evict   = is_store && !any_hit && !spill_hit && !any_free && !spill.vld;
    assign st_around  = is_store && !any_hit && !spill_hit && !any_free && spill.vld;
    assign fwd        = load_miss || st_around;

    // The drain uses the memory port only when upstream leaves it idle.
    assign drain_go   = (state == DRAIN) && spill.vld && (bus.cache2vb_command == BUS_NONE);
    assign drain_done = drain_go && (bus.mem2vb_response != 4'd0);

    // Steer both ports.
    // Upstream pass-through has priority over the drain.
    // A buffer return has priority over memory's return.
    always_comb begin
        bus.vb2cache_response = 4'd0;
        bus.vb2cache_tag      = ret_vld ? VB_TAG : bus.mem2vb_tag;
        bus.vb2cache_data     = ret_vld ? ret_data : bus.mem2vb_data;
        bus.vb2mem_address    = 32'd0;
        bus.vb2mem_data       = 64'd0;
        bus.vb2mem_command    = BUS_NONE;
        if (reset) begin
            bus.vb2cache_tag  = 4'd0;
            bus.vb2cache_data = 64'd0;
        end else if (fwd) begin
            bus.vb2mem_address    = bus.cache2vb_address;
            bus.vb2mem_data       = bus.cache2vb_data;
            bus.vb2mem_command    = bus.cache2vb_command;
            bus.vb2cache_response = bus.mem2vb_response;
        end else if (load_hit || st_ent || st_spill || st_free || st_evict) begin
            bus.vb2cache_response = VB_TAG;
        end else if (drain_go) begin
            bus.vb2mem_address = {spill.addr, 3'b000};
            bus.vb2mem_data    = spill.data;
            bus.vb2mem_command = BUS_STORE;
        end
    end

    // Update the entry array.
    // A hit line is invalidated because it migrates back to the d_cache.
    // Stores fill the lowest free entry, or else evict the entry at the
    // round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < VB_ENTRIES; i++) ent[i].vld <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (is_load && any_hit) ent[hit_idx].vld <= 1'b0;
            if (st_ent)             ent[hit_idx].data <= bus.cache2vb_data;
            if (st_free)            ent[free_idx] <= new_line;
            if (st_evict) begin
                ent[rr_ptr] <= new_line;
                rr_ptr      <= IDX_W'(rr_ptr + 1'b1);
            end
        end
    end

    // Spill register and drain FSM.
    // Going back to IDLE whenever the spill empties prevents a stale line
    // from being stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            spill <= '0;
            state <= IDLE;
        end else begin
            if (load_spill)      spill.vld  <= 1'b0;
            else if (st_spill)   spill.data <= bus.cache2vb_data;
            else if (st_evict)   spill      <= ent[rr_ptr];
            else if (drain_done) spill.vld  <= 1'b0;

            case (state)
                IDLE:    if (spill.vld && !load_spill) state <= DRAIN;
                DRAIN:   if (load_spill || drain_done || !spill.vld) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One-cycle return register for buffer-serviced loads.
    always_ff @(posedge clk) begin
        if (reset) begin
            ret_vld  <= 1'b0;
            ret_data <= 64'd0;
        end else begin
            ret_vld  <= load_hit;
            if (load_hit) ret_data <= any_hit ? ent[hit_idx].data : spill.data;
        end
    end

`ifdef VB_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;

    // Count buffer hits and loads that memory accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (load_hit) hit_cnt <= hit_cnt + 32'd1;
            if (load_miss && (bus.mem2vb_response != 4'd0)) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign vb_hit_counter  = hit_cnt;
    assign vb_miss_counter = miss_cnt;
`else
    assign vb_hit_counter  = 32'd0;
    assign vb_miss_counter = 32'd0;
`endif
endmodule

// File: tb/tb_victim_buffer.sv
// Directed bench for victim_buffer with VB_ENTRIES=4 and VB_TAG=15.
// Inputs are driven on the falling edge and outputs are sampled 1ns later.
// The expected counter values follow VB_STATS_EN.
module tb_victim_buffer;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
`ifdef VB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] hit_cnt, miss_cnt;
    int          n_chk = 0, n_fail = 0;

    victim_buffer_if bus();

    victim_buffer #(.VB_ENTRIES(4), .VB_TAG(4'd15)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .vb_hit_counter  (hit_cnt),
        .vb_miss_counter (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data,
                        input logic [3:0] mresp, input logic [3:0] mtag, input logic [63:0] mdata);
        @(negedge clk);
        bus.cache2vb_command = cmd;
        bus.cache2vb_address = addr;
        bus.cache2vb_data    = data;
        bus.mem2vb_response  = mresp;
        bus.mem2vb_tag       = mtag;
        bus.mem2vb_data      = mdata;
        #1;
    endtask

    initial begin
        bus.cache2vb_command = NONE;
        bus.cache2vb_address = '0;
        bus.cache2vb_data    = '0;
        bus.mem2vb_response  = '0;
        bus.mem2vb_tag       = '0;
        bus.mem2vb_data      = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp", 64'(bus.vb2cache_response), 64'd0);
        chk("rst_tag",  64'(bus.vb2cache_tag), 64'd0);
        chk("rst_mcmd", 64'(bus.vb2mem_command), 64'd0);
        chk("rst_hit",  64'(hit_cnt), 64'd0);
        chk("rst_miss", 64'(miss_cnt), 64'd0);
        reset = 1'b0;

        // 1: store then load hit, one-cycle return, then the line is gone
        step(STORE, 32'h1008, 64'hAAAA_5555_0000_1111, 4'd0, 4'd0, 64'd0);
        chk("t1_st_resp", 64'(bus.vb2cache_response), 64'd15);
        chk("t1_st_mcmd", 64'(bus.vb2mem_command), 64'(NONE));
        step(LOAD, 32'h1008, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t1_ld_resp", 64'(bus.vb2cache_response), 64'd15);
        chk("t1_ld_mcmd", 64'(bus.vb2mem_command), 64'(NONE));
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t1_ret_tag", 64'(bus.vb2cache_tag), 64'd15);
        chk("t1_ret_dat", bus.vb2cache_data, 64'hAAAA_5555_0000_1111);
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t1_ret_once", 64'(bus.vb2cache_tag), 64'd0);
        step(LOAD, 32'h1008, 64'd0, 4'd3, 4'd0, 64'd0);
        chk("t1_re_mcmd", 64'(bus.vb2mem_command), 64'(LOAD));
        chk("t1_re_resp", 64'(bus.vb2cache_response), 64'd3);

        // 2: load miss forwarded, memory return passes through
        step(LOAD, 32'h2000, 64'd0, 4'd3, 4'd0, 64'd0);
        chk("t2_mcmd", 64'(bus.vb2mem_command), 64'(LOAD));
        chk("t2_madr", 64'(bus.vb2mem_address), 64'h2000);
        chk("t2_resp", 64'(bus.vb2cache_response), 64'd3);
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd3, 64'h1234);
        chk("t2_tag", 64'(bus.vb2cache_tag), 64'd3);
        chk("t2_dat", bus.vb2cache_data, 64'h1234);
        step(LOAD, 32'h3000, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t2_nacc_resp", 64'(bus.vb2cache_response), 64'd0);
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t2_hitcnt",  64'(hit_cnt), 64'(STATS * 1));
        chk("t2_misscnt", 64'(miss_cnt), 64'(STATS * 2));

        // 3: fill four entries, fifth store spills line 0x00, drain retries
        for (int i = 0; i < 5; i++) begin
            step(STORE, 32'(i * 8), 64'(32'h100 + i), 4'd0, 4'd0, 64'd0);
            chk("t3_st_resp", 64'(bus.vb2cache_response), 64'd15);
        end
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t3_dr_mcmd", 64'(bus.vb2mem_command), 64'(STORE));
        chk("t3_dr_madr", 64'(bus.vb2mem_address), 64'h0);
        chk("t3_dr_mdat", bus.vb2mem_data, 64'h100);
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t3_retry", 64'(bus.vb2mem_command), 64'(STORE));
        step(NONE, 32'h0, 64'd0, 4'd2, 4'd0, 64'd0);
        chk("t3_acc_mcmd", 64'(bus.vb2mem_command), 64'(STORE));
        step(NONE, 32'h0, 64'd0, 4'd2, 4'd0, 64'd0);
        chk("t3_done", 64'(bus.vb2mem_command), 64'(NONE));

        // 4: buffer and spill full -> write-around (spill gets 0x08)
        step(STORE, 32'h28, 64'h105, 4'd0, 4'd0, 64'd0);
        chk("t4_evict_resp", 64'(bus.vb2cache_response), 64'd15);
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        step(STORE, 32'h40, 64'h140, 4'd0, 4'd0, 64'd0);
        chk("t4_wa_resp0", 64'(bus.vb2cache_response), 64'd0);
        chk("t4_wa_madr0", 64'(bus.vb2mem_address), 64'h40);
        step(STORE, 32'h40, 64'h140, 4'd5, 4'd0, 64'd0);
        chk("t4_wa_resp5", 64'(bus.vb2cache_response), 64'd5);
        chk("t4_wa_mcmd", 64'(bus.vb2mem_command), 64'(STORE));
        chk("t4_wa_mdat", bus.vb2mem_data, 64'h140);

        // 5: load hit on the spill register during DRAIN cancels the drain
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t5_dr_madr", 64'(bus.vb2mem_address), 64'h08);
        step(LOAD, 32'h08, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t5_ld_resp", 64'(bus.vb2cache_response), 64'd15);
        chk("t5_ld_mcmd", 64'(bus.vb2mem_command), 64'(NONE));
        step(NONE, 32'h0, 64'd0, 4'd7, 4'd0, 64'd0);
        chk("t5_ret_tag", 64'(bus.vb2cache_tag), 64'd15);
        chk("t5_ret_dat", bus.vb2cache_data, 64'h101);
        chk("t5_no_st", 64'(bus.vb2mem_command), 64'(NONE));
        step(NONE, 32'h0, 64'd0, 4'd7, 4'd0, 64'd0);
        chk("t5_idle", 64'(bus.vb2mem_command), 64'(NONE));
        chk("t5_hitcnt", 64'(hit_cnt), 64'(STATS * 2));

        // 6: reset mid-DRAIN (spill holds 0x10)
        step(STORE, 32'h30, 64'h130, 4'd0, 4'd0, 64'd0);
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);
        chk("t6_dr_madr", 64'(bus.vb2mem_address), 64'h10);
        @(negedge clk);
        reset = 1'b1;
        bus.mem2vb_response = 4'd3;
        @(negedge clk);
        #1;
        chk("t6_rst_mcmd", 64'(bus.vb2mem_command), 64'd0);
        chk("t6_rst_resp", 64'(bus.vb2cache_response), 64'd0);
        chk("t6_rst_tag",  64'(bus.vb2cache_tag), 64'd0);
        chk("t6_rst_hit",  64'(hit_cnt), 64'd0);
        chk("t6_rst_miss", 64'(miss_cnt), 64'd0);
        reset = 1'b0;
        step(LOAD, 32'h20, 64'd0, 4'd4, 4'd0, 64'd0);
        chk("t6_ent_miss", 64'(bus.vb2mem_command), 64'(LOAD));
        chk("t6_ent_resp", 64'(bus.vb2cache_response), 64'd4);
        step(LOAD, 32'h10, 64'd0, 4'd4, 4'd0, 64'd0);
        chk("t6_spill_miss", 64'(bus.vb2mem_command), 64'(LOAD));
        step(NONE, 32'h0, 64'd0, 4'd0, 4'd0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
